lcd_bus_scheduler: RTL and testbench
====================================

# lcd_bus_scheduler

Shares the single HD44780-style LCD write bus between two requesters: the power-up init sequencer and the display refresh engine. It grants the bus by fixed priority and latches the granted byte. It then generates the full bus timing: setup, E pulse, hold, and the command execution wait. The completing requester gets a one-cycle acknowledge, which replaces ad-hoc write strobes and finish flags in the LCD control path.

## Interface
Parameters:
- T_SETUP, 2: cycles that RS/DB are stable before E rises (≥1)
- T_EPULSE, 12: cycles E is high (≥1)
- T_HOLD, 2: cycles that RS/DB are held after E falls (≥1)
- T_WAIT, 2000: execution wait for normal writes (≥1)
- T_LONG, 82000: execution wait for clear/home commands (≥ T_WAIT)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- init_req  in  1  init sequencer requests a write; held until init_ack
- init_rs  in  1  RS for the init write (0 = command, 1 = data)
- init_data  in  8  byte for the init write
- init_ack  out  1  one-cycle pulse when the init write has fully completed
- ref_req  in  1  refresh engine requests a write; held until ref_ack
- ref_rs  in  1  RS for the refresh write
- ref_data  in  8  byte for the refresh write
- ref_ack  out  1  one-cycle pulse when the refresh write has fully completed
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied to 0
- lcd_db  out  8  LCD data bus
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SETUP, PULSE, HOLD, (NIBGAP), WAIT, ACK.
- IDLE:
  - init_req has priority over ref_req.
  - On grant, latch rs, data and owner, then go to SETUP.
  - With no request, stay in IDLE.
- SETUP: lcd_e=0 and lcd_rs/lcd_db driven from the latch for T_SETUP cycles, then PULSE.
- PULSE: lcd_e=1 for T_EPULSE cycles, then HOLD.
- HOLD: lcd_e=0 with bus unchanged for T_HOLD cycles, then WAIT.
- WAIT:
  - Lasts T_LONG cycles if the latched write is a long command (rs=0 and data[7:1]==7'b0000000 with data[0]=1, or data[7:1]==7'b0000001, i.e. 0x01/0x02/0x03).
  - Lasts T_WAIT cycles otherwise.
- ACK: exactly one cycle; pulse the owner's ack, then IDLE.
- Requests:
  - A requester must deassert req in the cycle after ack.
  - req still high when IDLE is next evaluated counts as a new write.
  - req and data changes while not granted are ignored; granted data comes only from the latch.
- Arbitration:
  - No preemption: a refresh write in flight completes before a pending init request is granted.
  - Simultaneous requests: init wins; ref waits.
- Counter: one down-counter sized $clog2(T_LONG+1) bits, loaded on every state entry, with the exit condition count==1.
- lcd_db/lcd_rs keep their last latched value in WAIT, ACK and IDLE.

## Timing
- Reset values:
  - state IDLE.
  - lcd_e, lcd_rs, lcd_rw, lcd_db, init_ack, ref_ack, busy all 0.
  - Counter and latch 0.
- Reset mid-operation: lcd_e drops asynchronously, no ack is issued, and the interrupted write is lost.
- Grant latency: a request high at clock edge E0 while in IDLE is granted at E0; busy goes high after E0.
- ack latency, 8-bit mode: ack is high in the cycle following edge E0+T_SETUP+T_EPULSE+T_HOLD+W, where W=T_WAIT or T_LONG.
  - Default normal write: 2016 cycles.
  - Default clear: 82016 cycles.
- The earliest next grant is the edge ending the ACK cycle + 1, i.e. one IDLE cycle between writes.

## Configuration
- LCD_NIBBLE_MODE_EN, defined: 4-bit bus.
  - Each write sends the high nibble, then the low nibble, on lcd_db[7:4]; lcd_db[3:0]=0.
  - Sequence: SETUP→PULSE→HOLD (high nibble), NIBGAP for T_HOLD cycles, then SETUP→PULSE→HOLD (low nibble), then WAIT once.
  - ack latency becomes 2·(T_SETUP+T_EPULSE+T_HOLD)+T_HOLD+W.
- LCD_NIBBLE_MODE_EN, undefined: 8-bit bus, the NIBGAP state is absent, single strobe per write.

## Structure
- Shared package lcd_pkg holds:
  - state encoding typedef
  - default timing constants
  - the long-command decode function (also used by the init sequencer)
- One sub-module is natural: lcd_timer, a loadable down-counter with a done flag.

## Test plan
- Single init write 0x38 rs=0 (default params, 8-bit) → lcd_e high for exactly 12 cycles starting 2 cycles after grant; init_ack is one pulse 2016 cycles after the grant edge; ref_ack stays 0.
- init_req and ref_req both high in the same IDLE cycle (data 0x01 / 0x41) → init granted first with a 82016-cycle clear wait, then the ref write of 0x41 with rs=1; the acks are in that order.
- ref write in flight and init_req rises mid-PULSE → the ref write completes unchanged; init is granted at the first IDLE after ref_ack.
- Requester changes ref_data from 0x41 to 0x55 during PULSE → lcd_db stays 0x41 for the whole transaction.
- rst asserted during PULSE → lcd_e, busy and the acks go to 0 immediately; after release, state is IDLE and a new request completes normally.
- With LCD_NIBBLE_MODE_EN, write 0xA5 rs=1 → lcd_db[7:4]=0xA on the first strobe and 0x5 on the second; two E pulses of 12 cycles; ack at 2·16+2+2000=2034 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: FSM encoding, requester IDs, default timing, long-command decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_NIBGAP = 3'd4,
        ST_WAIT   = 3'd5,
        ST_ACK    = 3'd6
    } state_e;

    typedef enum logic {
        OWN_INIT = 1'b0,
        OWN_REF  = 1'b1
    } owner_e;

    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_EPULSE_DEF = 12;
    localparam int unsigned T_HOLD_DEF   = 2;
    localparam int unsigned T_WAIT_DEF   = 2000;
    localparam int unsigned T_LONG_DEF   = 82000;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (((data[7:1] == 7'b0000000) && data[0]) || (data[7:1] == 7'b0000001));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done_c flags the last cycle of the loaded interval.
module lcd_timer #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] count_q, count_d;

    // Load on request, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != W'(0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= W'(0);
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == W'(1));

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Fixed-priority arbiter and HD44780 write-timing generator for the shared LCD bus.
// Build option: LCD_NIBBLE_MODE_EN selects the 4-bit bus (two strobes per write).
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_EPULSE = T_EPULSE_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned T_WAIT   = T_WAIT_DEF,
    parameter int unsigned T_LONG   = T_LONG_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       init_rs,
    input  logic [7:0] init_data,
    output logic       init_ack,
    input  logic       ref_req,
    input  logic       ref_rs,
    input  logic [7:0] ref_data,
    output logic       ref_ack,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(T_LONG + 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             init_ack_q, init_ack_d;
    logic             ref_ack_q, ref_ack_d;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_done_c;
    logic             grant_c;
`ifdef LCD_NIBBLE_MODE_EN
    logic             phase_q, phase_d;
    logic [7:0]       db_q, db_d;
`endif

    lcd_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each timed phase exits when the timer reaches one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (init_req || ref_req) state_d = ST_SETUP;
            ST_SETUP: if (tmr_done_c) state_d = ST_PULSE;
            ST_PULSE: if (tmr_done_c) state_d = ST_HOLD;
`ifdef LCD_NIBBLE_MODE_EN
            ST_HOLD:   if (tmr_done_c) state_d = phase_q ? ST_WAIT : ST_NIBGAP;
            ST_NIBGAP: if (tmr_done_c) state_d = ST_SETUP;
`else
            ST_HOLD:   if (tmr_done_c) state_d = ST_WAIT;
            ST_NIBGAP: state_d = ST_IDLE;
`endif
            ST_WAIT:  if (tmr_done_c) state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Timer reload on every state entry with the duration of the state being entered.
    always_comb begin
        tmr_load_c = (state_d != state_q);
        case (state_d)
            ST_SETUP:  tmr_val_c = CNT_W'(T_SETUP);
            ST_PULSE:  tmr_val_c = CNT_W'(T_EPULSE);
            ST_HOLD:   tmr_val_c = CNT_W'(T_HOLD);
            ST_NIBGAP: tmr_val_c = CNT_W'(T_HOLD);
            ST_WAIT:   tmr_val_c = is_long_cmd(rs_q, data_q) ? CNT_W'(T_LONG) : CNT_W'(T_WAIT);
            ST_ACK:    tmr_val_c = CNT_W'(1);
            default:   tmr_val_c = CNT_W'(0);
        endcase
    end

    // Output/datapath logic: latch the winner on grant, decode bus strobes from the next state.
    always_comb begin
        grant_c = (state_q == ST_IDLE) && (state_d == ST_SETUP);
        owner_d = owner_q;
        rs_d    = rs_q;
        data_d  = data_q;
        if (grant_c) begin
            if (init_req) begin
                owner_d = OWN_INIT;
                rs_d    = init_rs;
                data_d  = init_data;
            end else begin
                owner_d = OWN_REF;
                rs_d    = ref_rs;
                data_d  = ref_data;
            end
        end
`ifdef LCD_NIBBLE_MODE_EN
        phase_d = phase_q;
        if (grant_c) begin
            phase_d = 1'b0;
        end else if ((state_q == ST_NIBGAP) && (state_d == ST_SETUP)) begin
            phase_d = 1'b1;
        end
        db_d = db_q;
        if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
            db_d = phase_d ? {data_d[3:0], 4'h0} : {data_d[7:4], 4'h0};
        end
`endif
        e_d        = (state_d == ST_PULSE);
        busy_d     = (state_d != ST_IDLE);
        init_ack_d = (state_d == ST_ACK) && (owner_d == OWN_INIT);
        ref_ack_d  = (state_d == ST_ACK) && (owner_d == OWN_REF);
    end

    // Output and latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_INIT;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            e_q        <= 1'b0;
            busy_q     <= 1'b0;
            init_ack_q <= 1'b0;
            ref_ack_q  <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
            phase_q    <= 1'b0;
            db_q       <= 8'h00;
`endif
        end else begin
            owner_q    <= owner_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            e_q        <= e_d;
            busy_q     <= busy_d;
            init_ack_q <= init_ack_d;
            ref_ack_q  <= ref_ack_d;
`ifdef LCD_NIBBLE_MODE_EN
            phase_q    <= phase_d;
            db_q       <= db_d;
`endif
        end
    end

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
    assign lcd_db   = db_q;
`else
    assign lcd_db   = data_q;
`endif
    assign busy     = busy_q;
    assign init_ack = init_ack_q;
    assign ref_ack  = ref_ack_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench for lcd_bus_scheduler: directed writes, arbitration, data stability, reset.
module tb_lcd_bus_scheduler;

    localparam int TS = 2;
    localparam int TP = 12;
    localparam int TH = 2;
    localparam int TW = 2000;
    localparam int TL = 8200;
`ifdef LCD_NIBBLE_MODE_EN
    localparam int NSTROBE = 2;
    localparam int BASE    = 2 * (TS + TP + TH) + TH;
`else
    localparam int NSTROBE = 1;
    localparam int BASE    = TS + TP + TH;
`endif
    localparam int LIMIT = TL + 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_req, init_rs, ref_req, ref_rs;
    logic [7:0] init_data, ref_data;
    logic       init_ack, ref_ack, lcd_e, lcd_rs, lcd_rw, busy;
    logic [7:0] lcd_db;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       own;   // 0 = init, 1 = refresh
        logic       rs;
        logic [7:0] data;
        logic       b2b;   // expected grant on the first IDLE after the previous ack
    } txn_t;

    txn_t sb[$];

    lcd_bus_scheduler #(
        .T_SETUP(TS), .T_EPULSE(TP), .T_HOLD(TH), .T_WAIT(TW), .T_LONG(TL)
    ) dut (
        .clk(clk), .rst(rst),
        .init_req(init_req), .init_rs(init_rs), .init_data(init_data), .init_ack(init_ack),
        .ref_req(ref_req), .ref_rs(ref_rs), .ref_data(ref_data), .ref_ack(ref_ack),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic rs, input logic [7:0] d);
        logic long_cmd;
        long_cmd = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        return BASE + (long_cmd ? TL : TW);
    endfunction

    function automatic logic [7:0] exp_db(input logic [7:0] d, input int idx);
`ifdef LCD_NIBBLE_MODE_EN
        return (idx == 0) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
`else
        return (idx == 0) ? d : d;
`endif
    endfunction

    task automatic push(input logic own, input logic rs, input logic [7:0] d, input logic b2b);
        txn_t t;
        t.own = own; t.rs = rs; t.data = d; t.b2b = b2b;
        sb.push_back(t);
    endtask

    task automatic wait_ack(output logic gi, output logic gr);
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (init_ack || ref_ack) break;
        end
        gi = init_ack;
        gr = ref_ack;
        chk("ack_timeout", 32'(gi | gr), 32'd1);
    endtask

    // Monitor: pops the scoreboard on each grant and checks strobes, bus values and ack.
    txn_t cur;
    logic active = 1'b0;
    logic e_prev = 1'b0, busy_prev = 1'b0, ack_prev = 1'b0;
    int   cyc = 0, g_cyc = 0, e_start = 0, npulse = 0, last_ack = -100;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            active = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                chk("grant_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    g_cyc  = cyc;
                    npulse = 0;
                    if (cur.b2b) chk("b2b_grant_gap", 32'(cyc - last_ack), 32'd2);
                end
            end
            if (active && lcd_e && !e_prev) begin
                e_start = cyc;
                chk("strobe_rs", 32'(lcd_rs), 32'(cur.rs));
                if (npulse == 0) chk("e_rise_offset", 32'(cyc - g_cyc), 32'(TS));
            end
            if (active && lcd_e) chk("db_during_e", 32'(lcd_db), 32'(exp_db(cur.data, npulse)));
            if (active && !lcd_e && e_prev) begin
                chk("e_width", 32'(cyc - e_start), 32'(TP));
                npulse++;
            end
            if (init_ack || ref_ack) begin
                chk("ack_one_cycle", 32'(ack_prev), 32'd0);
                chk("ack_has_txn", 32'(active), 32'd1);
                if (active) begin
                    chk("ack_owner_init", 32'(init_ack), 32'(!cur.own));
                    chk("ack_owner_ref", 32'(ref_ack), 32'(cur.own));
                    chk("ack_latency", 32'(cyc - g_cyc), 32'(exp_lat(cur.rs, cur.data)));
                    chk("strobe_count", 32'(npulse), 32'(NSTROBE));
                end
                active   = 1'b0;
                last_ack = cyc;
            end
        end
        e_prev    = lcd_e;
        busy_prev = busy;
        ack_prev  = init_ack || ref_ack;
    end

    logic gi, gr;

    initial begin
        rst = 1'b1;
        init_req = 1'b0; init_rs = 1'b0; init_data = 8'h00;
        ref_req  = 1'b0; ref_rs  = 1'b0; ref_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_lcd_e", 32'(lcd_e), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        chk("rst_lcd_db", 32'(lcd_db), 32'd0);
        chk("rst_acks", 32'({init_ack, ref_ack}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single init write 0x38 command.
        push(1'b0, 1'b0, 8'h38, 1'b0);
        init_req = 1'b1; init_rs = 1'b0; init_data = 8'h38;
        wait_ack(gi, gr);
        init_req = 1'b0;
        chk("t1_init_ack", 32'(gi), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_db_kept", 32'(lcd_db), 32'(exp_db(8'h38, NSTROBE - 1)));
        chk("t1_rw", 32'(lcd_rw), 32'd0);

        // Simultaneous requests: init clear first, then refresh data 0x41.
        push(1'b0, 1'b0, 8'h01, 1'b0);
        push(1'b1, 1'b1, 8'h41, 1'b1);
        init_req = 1'b1; init_rs = 1'b0; init_data = 8'h01;
        ref_req  = 1'b1; ref_rs  = 1'b1; ref_data  = 8'h41;
        wait_ack(gi, gr);
        init_req = 1'b0;
        chk("t2_first_is_init", 32'({gi, gr}), 32'b10);
        wait_ack(gi, gr);
        ref_req = 1'b0;
        chk("t2_second_is_ref", 32'({gi, gr}), 32'b01);
        repeat (3) @(negedge clk);

        // Refresh in flight; init arrives and refresh data changes mid-PULSE.
        push(1'b1, 1'b1, 8'h41, 1'b0);
        push(1'b0, 1'b0, 8'h04, 1'b1);
        ref_req = 1'b1; ref_rs = 1'b1; ref_data = 8'h41;
        repeat (6) @(negedge clk);
        chk("t3_in_pulse", 32'(lcd_e), 32'd1);
        init_req = 1'b1; init_rs = 1'b0; init_data = 8'h04;
        ref_data = 8'h55; ref_rs = 1'b0;
        wait_ack(gi, gr);
        ref_req = 1'b0;
        chk("t3_ref_completes", 32'({gi, gr}), 32'b01);
        wait_ack(gi, gr);
        init_req = 1'b0;
        chk("t3_init_next", 32'({gi, gr}), 32'b10);
        repeat (3) @(negedge clk);

        // Long-command boundaries: 0x02 command is long, 0x01 as data is normal.
        push(1'b1, 1'b0, 8'h02, 1'b0);
        ref_req = 1'b1; ref_rs = 1'b0; ref_data = 8'h02;
        wait_ack(gi, gr);
        ref_req = 1'b0;
        repeat (2) @(negedge clk);
        push(1'b1, 1'b1, 8'h01, 1'b0);
        ref_req = 1'b1; ref_rs = 1'b1; ref_data = 8'h01;
        wait_ack(gi, gr);
        ref_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during PULSE kills the write without an ack.
        push(1'b0, 1'b0, 8'h38, 1'b0);
        init_req = 1'b1; init_rs = 1'b0; init_data = 8'h38;
        repeat (6) @(negedge clk);
        chk("t5_in_pulse", 32'(lcd_e), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_lcd_e", 32'(lcd_e), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_acks", 32'({init_ack, ref_ack}), 32'd0);
        init_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_idle_after_rst", 32'(busy), 32'd0);
        chk("t5_no_ack_after_rst", 32'({init_ack, ref_ack}), 32'd0);

        // Normal write after reset (0xA5 data exercises both nibbles).
        push(1'b1, 1'b1, 8'hA5, 1'b0);
        ref_req = 1'b1; ref_rs = 1'b1; ref_data = 8'hA5;
        wait_ack(gi, gr);
        ref_req = 1'b0;
        chk("t6_ref_ack", 32'(gr), 32'd1);
        repeat (4) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
